// File: rtl/victim_way_sel_pkg.sv
// Shared definitions for the victim way selector.
//   state_t       : controller FSM states (IDLE -> SEL -> OUT -> IDLE)
//   onehot_to_bin : binary index of a one-hot vector
//   is_onehot     : exactly-one-bit-set test
// Helpers operate on a MAX_WAYS-wide vector; callers zero-extend narrower vectors.
package victim_way_sel_pkg;

  localparam int unsigned MAX_WAYS = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    OUT
  } state_t;

  function automatic int unsigned onehot_to_bin(input logic [MAX_WAYS-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_WAYS-1:0] v);
    return (v != '0) && ((v & (v - MAX_WAYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/victim_way_sel_rr_ptr_table.sv
// Per-set round-robin pointer table.
//   clk, rst_n : clock, asynchronous active-low clear of every pointer
//   set_idx    : set whose pointer is read and (optionally) advanced
//   ptr        : current pointer of set_idx
//   adv        : advance ptr[set_idx] by one, wrapping at WAY_NUM-1
module rr_ptr_table #(
  parameter  int unsigned WAY_NUM = 4,
  parameter  int unsigned SET_NUM = 64,
  localparam int unsigned WAY_W   = $clog2(WAY_NUM),
  localparam int unsigned SET_W   = $clog2(SET_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SET_W-1:0] set_idx,
  output logic [WAY_W-1:0] ptr,
  input  logic             adv
);

  logic [WAY_W-1:0] ptr_q [SET_NUM];

  assign ptr = ptr_q[set_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SET_NUM; i++) ptr_q[i] <= '0;
    end else if (adv) begin
      // explicit wrap so non-power-of-two way counts never reach WAY_NUM
      ptr_q[set_idx] <= (ptr_q[set_idx] == WAY_W'(WAY_NUM - 1)) ? '0
                                                                 : ptr_q[set_idx] + WAY_W'(1);
    end
  end

endmodule

// File: rtl/victim_way_sel.sv
// Victim way selector for cache refills.
// Prefers an invalid way (chosen by an external lowest-index-wins arbiter fed
// with the invalid mask), else falls back to a per-set round-robin pointer.
//   req_valid/req_ready/req_set/req_way_valid : request from the refill FSM
//   arb_req/arb_grant/arb_grant_valid         : external fixed-priority arbiter
//   vic_valid/vic_ready/vic_way_oh/vic_way_idx/vic_from_inv : victim result
//   err_grant : sticky flag, arbiter reported a zero or multi-hot grant
module victim_way_sel
  import victim_way_sel_pkg::*;
#(
  parameter  int unsigned WAY_NUM = 4,
  parameter  int unsigned SET_NUM = 64,
  localparam int unsigned WAY_W   = $clog2(WAY_NUM),
  localparam int unsigned SET_W   = $clog2(SET_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SET_W-1:0]   req_set,
  input  logic [WAY_NUM-1:0] req_way_valid,
  output logic [WAY_NUM-1:0] arb_req,
  input  logic [WAY_NUM-1:0] arb_grant,
  input  logic               arb_grant_valid,
  output logic               vic_valid,
  input  logic               vic_ready,
  output logic [WAY_NUM-1:0] vic_way_oh,
  output logic [WAY_W-1:0]   vic_way_idx,
  output logic               vic_from_inv,
  output logic               err_grant
);

  state_t             state;
  logic [SET_W-1:0]   set_q;
  logic [WAY_W-1:0]   rr_ptr;
  logic               ptr_adv;
  logic               grant_ok;
  logic [WAY_NUM-1:0] sel_oh;

  rr_ptr_table #(
    .WAY_NUM (WAY_NUM),
    .SET_NUM (SET_NUM)
  ) u_rr_ptr_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_idx (set_q),
    .ptr     (rr_ptr),
    .adv     (ptr_adv)
  );

  always_comb begin
    grant_ok = arb_grant_valid && is_onehot(MAX_WAYS'(arb_grant));
    sel_oh   = grant_ok ? arb_grant : (WAY_NUM'(1) << rr_ptr);
    // only round-robin victims consume a pointer slot
    ptr_adv  = (state == OUT) && vic_ready && !vic_from_inv;
  end

  // arb_req doubles as the latched invalid-way mask; it is loaded on
  // acceptance and cleared on leaving SEL, so it is nonzero only in SEL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      set_q        <= '0;
      arb_req      <= '0;
      vic_valid    <= 1'b0;
      vic_way_oh   <= '0;
      vic_way_idx  <= '0;
      vic_from_inv <= 1'b0;
      err_grant    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            set_q     <= req_set;
            arb_req   <= ~req_way_valid;
            req_ready <= 1'b0;
            state     <= SEL;
          end
        end
        SEL: begin
          arb_req      <= '0;
          vic_way_oh   <= sel_oh;
          vic_way_idx  <= WAY_W'(onehot_to_bin(MAX_WAYS'(sel_oh)));
          vic_from_inv <= grant_ok;
          if (arb_grant_valid && !grant_ok) err_grant <= 1'b1;
          vic_valid    <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (vic_ready) begin
            vic_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          vic_valid <= 1'b0;
          req_ready <= 1'b1;
          arb_req   <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_victim_way_sel.sv
module tb_victim_way_sel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4-way instance
  logic       req_valid, req_ready, arb_grant_valid, vic_valid, vic_ready, vic_from_inv, err_grant;
  logic [5:0] req_set;
  logic [3:0] req_way_valid, arb_req, arb_grant, vic_way_oh;
  logic [1:0] vic_way_idx;
  logic       force_en;
  logic [3:0] force_grant;

  // 3-way instance
  logic       req_valid3, req_ready3, arb_grant_valid3, vic_valid3, vic_ready3, vic_from_inv3, err_grant3;
  logic [5:0] req_set3;
  logic [2:0] req_way_valid3, arb_req3, arb_grant3, vic_way_oh3;
  logic [1:0] vic_way_idx3;

  victim_way_sel #(.WAY_NUM(4), .SET_NUM(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_way_valid(req_way_valid), .arb_req(arb_req),
    .arb_grant(arb_grant), .arb_grant_valid(arb_grant_valid), .vic_valid(vic_valid),
    .vic_ready(vic_ready), .vic_way_oh(vic_way_oh), .vic_way_idx(vic_way_idx),
    .vic_from_inv(vic_from_inv), .err_grant(err_grant)
  );

  victim_way_sel #(.WAY_NUM(3), .SET_NUM(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_set(req_set3), .req_way_valid(req_way_valid3), .arb_req(arb_req3),
    .arb_grant(arb_grant3), .arb_grant_valid(arb_grant_valid3), .vic_valid(vic_valid3),
    .vic_ready(vic_ready3), .vic_way_oh(vic_way_oh3), .vic_way_idx(vic_way_idx3),
    .vic_from_inv(vic_from_inv3), .err_grant(err_grant3)
  );

  // external fixed-priority arbiters: lowest set bit wins
  always_comb begin
    if (force_en) begin
      arb_grant       = force_grant;
      arb_grant_valid = 1'b1;
    end else begin
      arb_grant       = arb_req & (~arb_req + 4'd1);
      arb_grant_valid = |arb_req;
    end
    arb_grant3       = arb_req3 & (~arb_req3 + 3'd1);
    arb_grant_valid3 = |arb_req3;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // full request/ack transaction on the 4-way instance with exact latency
  task automatic req4(input logic [5:0] s, input logic [3:0] wv, input logic [3:0] eoh,
                      input logic [1:0] eidx, input logic einv);
    logic [3:0] inv;
    inv = ~wv;
    @(negedge clk);
    req_valid = 1'b1; req_set = s; req_way_valid = wv;
    @(negedge clk);                       // SEL
    req_valid = 1'b0;
    chk("sel_arb_req", arb_req, inv);
    chk("sel_req_ready", req_ready, 1'b0);
    chk("sel_vic_valid", vic_valid, 1'b0);
    @(negedge clk);                       // OUT, N+2
    chk("out_vic_valid", vic_valid, 1'b1);
    chk("out_vic_oh", vic_way_oh, eoh);
    chk("out_vic_idx", vic_way_idx, eidx);
    chk("out_vic_inv", vic_from_inv, einv);
    chk("out_arb_req", arb_req, 4'b0000);
    vic_ready = 1'b1;
    @(negedge clk);                       // back in IDLE
    vic_ready = 1'b0;
    chk("idle_vic_valid", vic_valid, 1'b0);
    chk("idle_req_ready", req_ready, 1'b1);
    chk("idle_vic_oh_hold", vic_way_oh, eoh);
  endtask

  task automatic req3(input logic [2:0] eoh, input logic [1:0] eidx);
    @(negedge clk);
    req_valid3 = 1'b1; req_set3 = 6'd0; req_way_valid3 = 3'b111;
    @(negedge clk);
    req_valid3 = 1'b0;
    chk("w3_arb_req", arb_req3, 3'b000);
    @(negedge clk);
    chk("w3_vic_valid", vic_valid3, 1'b1);
    chk("w3_vic_oh", vic_way_oh3, eoh);
    chk("w3_vic_idx", vic_way_idx3, eidx);
    chk("w3_vic_inv", vic_from_inv3, 1'b0);
    vic_ready3 = 1'b1;
    @(negedge clk);
    vic_ready3 = 1'b0;
    chk("w3_idle_vic_valid", vic_valid3, 1'b0);
  endtask

  typedef struct {
    logic [5:0] s;
    logic [3:0] wv;
    logic [3:0] oh;
    logic [1:0] idx;
    logic       inv;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    req_valid = 0; req_set = '0; req_way_valid = '0; vic_ready = 0;
    force_en = 0; force_grant = '0;
    req_valid3 = 0; req_set3 = '0; req_way_valid3 = '0; vic_ready3 = 0;

    tbl[0]  = '{6'd5,  4'b1011, 4'b0100, 2'd2, 1'b1}; // invalid way 2, ptr5 stays 0
    tbl[1]  = '{6'd3,  4'b1111, 4'b0001, 2'd0, 1'b0};
    tbl[2]  = '{6'd3,  4'b1111, 4'b0010, 2'd1, 1'b0};
    tbl[3]  = '{6'd3,  4'b1111, 4'b0100, 2'd2, 1'b0};
    tbl[4]  = '{6'd3,  4'b1111, 4'b1000, 2'd3, 1'b0};
    tbl[5]  = '{6'd3,  4'b1111, 4'b0001, 2'd0, 1'b0}; // wrap
    tbl[6]  = '{6'd5,  4'b1111, 4'b0001, 2'd0, 1'b0}; // ptr5 untouched by invalid victim
    tbl[7]  = '{6'd3,  4'b1111, 4'b0010, 2'd1, 1'b0}; // ptr3 is 1 after wrap
    tbl[8]  = '{6'd9,  4'b1110, 4'b0001, 2'd0, 1'b1};
    tbl[9]  = '{6'd9,  4'b0111, 4'b1000, 2'd3, 1'b1};
    tbl[10] = '{6'd9,  4'b1111, 4'b0001, 2'd0, 1'b0};
    tbl[11] = '{6'd63, 4'b0000, 4'b0001, 2'd0, 1'b1};

    // reset state
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_vic_valid", vic_valid, 1'b0);
    chk("rst_arb_req", arb_req, 4'b0000);
    chk("rst_vic_oh", vic_way_oh, 4'b0000);
    chk("rst_vic_idx", vic_way_idx, 2'd0);
    chk("rst_vic_inv", vic_from_inv, 1'b0);
    chk("rst_err", err_grant, 1'b0);
    chk("rst3_req_ready", req_ready3, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      req4(tbl[i].s, tbl[i].wv, tbl[i].oh, tbl[i].idx, tbl[i].inv);
    end
    chk("err_clear_after_table", err_grant, 1'b0);

    // stall in OUT: set 3 ptr is 2; request held during the stall is ignored
    @(negedge clk);
    req_valid = 1'b1; req_set = 6'd3; req_way_valid = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("stall_vic_valid", vic_valid, 1'b1);
      chk("stall_vic_oh", vic_way_oh, 4'b0100);
      chk("stall_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    chk("stall_last_vic_valid", vic_valid, 1'b1);
    vic_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    vic_ready = 1'b0;
    chk("stall_done_vic_valid", vic_valid, 1'b0);
    chk("stall_done_req_ready", req_ready, 1'b1);

    // multi-hot grant: fallback to ptr3 = 3, sticky error
    force_en = 1'b1; force_grant = 4'b0110;
    req4(6'd3, 4'b1011, 4'b1000, 2'd3, 1'b0);
    force_en = 1'b0;
    chk("err_set", err_grant, 1'b1);
    req4(6'd5, 4'b1111, 4'b0010, 2'd1, 1'b0);
    chk("err_sticky", err_grant, 1'b1);
    req4(6'd3, 4'b1111, 4'b0001, 2'd0, 1'b0);   // ptr3 wrapped 3 -> 0

    // reset while in OUT with ptr7 = 2
    req4(6'd7, 4'b1111, 4'b0001, 2'd0, 1'b0);
    req4(6'd7, 4'b1111, 4'b0010, 2'd1, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_set = 6'd7; req_way_valid = 4'b1111;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_vic_valid", vic_valid, 1'b1);
    chk("pre_rst_vic_oh", vic_way_oh, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vic_valid", vic_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_err", err_grant, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req4(6'd7, 4'b1111, 4'b0001, 2'd0, 1'b0);

    // 3-way: victims 0,1,2 then wrap to 0
    req3(3'b001, 2'd0);
    req3(3'b010, 2'd1);
    req3(3'b100, 2'd2);
    req3(3'b001, 2'd0);
    chk("w3_err", err_grant3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/victim_way_sel.md
Name: victim_way_sel

Overview:
- Cache replacement controller that picks the victim way for a refill.
- Drives the request vector of an external fixed-priority arbiter (lowest index wins) with the set's invalid-way mask, then consumes that arbiter's one-hot grant.
- Falls back to a per-set round-robin pointer when all ways are valid.
- Sits between the miss/refill FSM (request side) and the data/tag write path (victim side), with valid/ready handshakes on both.

Parameters:
- WAY_NUM, 4, number of ways; >=2, need not be a power of two.
- SET_NUM, 64, number of sets.
- WAY_W, $clog2(WAY_NUM), way index width (localparam).
- SET_W, $clog2(SET_NUM), set index width (localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  refill FSM requests a victim.
- req_ready  out  1  block can accept a request.
- req_set  in  SET_W  set index of the miss.
- req_way_valid  in  WAY_NUM  valid bits of the set's ways.
- arb_req  out  WAY_NUM  request vector to the external arbiter.
- arb_grant  in  WAY_NUM  one-hot grant from the arbiter (combinational from arb_req).
- arb_grant_valid  in  1  arbiter reports at least one request.
- vic_valid  out  1  victim result valid.
- vic_ready  in  1  consumer accepts the victim.
- vic_way_oh  out  WAY_NUM  one-hot victim way.
- vic_way_idx  out  WAY_W  binary victim way.
- vic_from_inv  out  1  victim was an invalid way (no writeback needed).
- err_grant  out  1  sticky: grant_valid seen with a non-one-hot grant.

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0 except req_ready=1; every rr_ptr[set]=0; latched registers=0.
- FSM states: IDLE -> SEL -> OUT -> IDLE.
- IDLE:
  - req_ready=1; arb_req=0.
  - On req_valid: latch set_q=req_set and inv_q=~req_way_valid; go to SEL.
- SEL (1 cycle):
  - req_ready=0; arb_req=inv_q.
  - Sample arb_grant/arb_grant_valid.
  - If arb_grant_valid and grant is one-hot: vic_way_oh<=arb_grant, vic_from_inv<=1.
  - Else: vic_way_oh<=onehot(rr_ptr[set_q]), vic_from_inv<=0.
  - If arb_grant_valid with a zero or multi-hot grant: set err_grant and use the round-robin fallback.
  - vic_way_idx <= binary encode of vic_way_oh.
  - Go to OUT.
- OUT:
  - vic_valid=1. vic_way_oh, vic_way_idx and vic_from_inv are held stable until vic_ready.
  - On vic_ready: if vic_from_inv=0, rr_ptr[set_q] <= (ptr==WAY_NUM-1) ? 0 : ptr+1. Invalid-way victims never advance the pointer.
  - vic_valid deasserts the next cycle; go to IDLE.
- Latency and throughput: request accepted in cycle N -> vic_valid in cycle N+2 (earliest). Minimum 3 cycles per request.
- req_ready is deasserted in SEL and OUT; req_valid there is ignored and must be held by the requester.
- arb_req is nonzero only in SEL.
- Outputs in IDLE: vic_* hold their last values but vic_valid=0.
- Pointer update happens only on the OUT handshake. A following request to the same set reads the updated pointer (no hazard: at least one IDLE cycle in between).
- Reset mid-operation: abort to IDLE, vic_valid=0, all pointers cleared, err_grant cleared.
- err_grant stays set until reset.

Decomposition:
- Shared cache package:
  - state enum (IDLE/SEL/OUT);
  - onehot-to-binary function;
  - is_onehot function.
- Sub-module rr_ptr_table: SET_NUM x WAY_W register array with async clear, read port (set_q) and write enable/increment-with-wrap port.

Test Plan:
- WAY_NUM=4, set 5, req_way_valid=4'b1011 -> arb_req=4'b0100 in SEL; vic_way_oh=4'b0100, idx=2, vic_from_inv=1 at cycle N+2; rr_ptr[5] unchanged (0).
- Set 3 all valid (4'b1111), five sequential requests, each acked -> victims 0,1,2,3,0; vic_from_inv=0; rr_ptr[3] wraps to 1 after the fifth.
- WAY_NUM=3, set 0 all valid, three requests -> victims 0,1,2, then pointer wraps to 0 (no index 3).
- vic_ready held low 4 cycles in OUT -> vic_valid and vic_way_oh stable; req_ready=0; a new req_valid is not accepted until after the handshake.
- Force arb_grant=4'b0110 with arb_grant_valid=1 -> err_grant=1 (sticky); victim taken from rr_ptr; vic_from_inv=0.
- rst_n pulled low while in OUT with rr_ptr[7]=2 -> vic_valid=0 immediately, req_ready=1; next all-valid request to set 7 -> victim 0.
